// File: rtl/bl_wl_frame_programmer.sv
// rtl/bl_wl_frame_programmer.sv - assembles bitline frames from a byte stream and strobes one wordline per row
// Optional per-frame parity check beat is enabled by defining BL_WL_FRAME_PARITY_EN.
module bl_wl_frame_programmer #(
  parameter int BL_W      = 160,
  parameter int WL_W      = 160,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic [0:BL_W-1]   bl,
  output logic [0:WL_W-1]   wl,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BEATS  = BL_W / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W  = (WL_W > 1) ? $clog2(WL_W) : 1;
  localparam int T_MAX  = (SETUP_CYC > PULSE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int TCNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(WL_W - 1);
  localparam logic [TCNT_W-1:0] SETUP_LAST = TCNT_W'(SETUP_CYC - 1);
  localparam logic [TCNT_W-1:0] PULSE_LAST = TCNT_W'(PULSE_CYC - 1);
  localparam logic [TCNT_W-1:0] HOLD_LAST  = TCNT_W'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [BL_W-1:0]    shadow_q, shadow_d;

  logic               din_ready_q, din_ready_d;
  logic [0:BL_W-1]    bl_q, bl_d;
  logic [0:WL_W-1]    wl_q, wl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               drive_bl;

  // Handshake uses the registered ready, so din_valid never reaches din_ready combinationally.
  assign accept = din_valid && din_ready_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    beat_d   = beat_q;
    tcnt_d   = tcnt_q;
    shadow_d = shadow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          beat_d  = '0;
          tcnt_d  = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          shadow_d[int'(beat_q)*DATA_W +: DATA_W] = din;
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
`ifdef BL_WL_FRAME_PARITY_EN
            state_d = S_CHECK;
`else
            state_d = S_SETUP;
`endif
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
`ifdef BL_WL_FRAME_PARITY_EN
      S_CHECK: begin
        // A failed check abandons the row before any wordline is touched.
        if (accept) begin
          state_d = (din[0] == ^shadow_q) ? S_SETUP : S_ERR;
        end
      end
`endif
      S_SETUP: begin
        if (tcnt_q == SETUP_LAST) begin
          tcnt_d  = '0;
          state_d = S_PULSE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (tcnt_q == PULSE_LAST) begin
          tcnt_d  = '0;
          state_d = S_HOLD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (tcnt_q == HOLD_LAST) begin
          tcnt_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are derived from the next state so every port comes straight off a flop.
  always_comb begin
    drive_bl    = state_d inside {S_SETUP, S_PULSE, S_HOLD};
    din_ready_d = state_d inside {S_LOAD, S_CHECK};
    busy_d      = din_ready_d || drive_bl;
    done_d      = (state_d == S_DONE);
`ifdef BL_WL_FRAME_PARITY_EN
    err_d       = (state_d == S_ERR);
`else
    err_d       = 1'b0;
`endif
    bl_d = '0;
    for (int i = 0; i < BL_W; i++) begin
      bl_d[i] = drive_bl & shadow_d[i];
    end
    wl_d = '0;
    if (state_d == S_PULSE) begin
      wl_d[row_d] = 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      beat_q      <= '0;
      tcnt_q      <= '0;
      shadow_q    <= '0;
      din_ready_q <= 1'b0;
      bl_q        <= '0;
      wl_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      beat_q      <= beat_d;
      tcnt_q      <= tcnt_d;
      shadow_q    <= shadow_d;
      din_ready_q <= din_ready_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign din_ready = din_ready_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bl_wl_frame_programmer.sv
// tb/tb_bl_wl_frame_programmer.sv - scoreboard bench for bl_wl_frame_programmer
module tb_bl_wl_frame_programmer;

  localparam int BL_W      = 160;
  localparam int WL_W      = 160;
  localparam int DATA_W    = 8;
  localparam int BEATS     = BL_W / DATA_W;
  localparam int SETUP_CYC = 1;
  localparam int PULSE_CYC = 2;
  localparam int HOLD_CYC  = 1;
`ifdef BL_WL_FRAME_PARITY_EN
  localparam int CHK_BEATS = 1;
`else
  localparam int CHK_BEATS = 0;
`endif
  localparam int ROW_CYC     = BEATS + CHK_BEATS + SETUP_CYC + PULSE_CYC + HOLD_CYC;
  localparam int FIRST_PULSE = BEATS + CHK_BEATS + SETUP_CYC;

  logic              prog_clk  = 1'b0;
  logic              pReset    = 1'b1;
  logic              start     = 1'b0;
  logic              din_valid = 1'b0;
  logic [DATA_W-1:0] din       = '0;
  logic              din_ready;
  logic [0:BL_W-1]   bl;
  logic [0:WL_W-1]   wl;
  logic              busy;
  logic              done;
  logic              err;

  bl_wl_frame_programmer #(
    .BL_W(BL_W), .WL_W(WL_W), .DATA_W(DATA_W),
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .bl(bl), .wl(wl), .busy(busy), .done(done), .err(err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    int              row;
    logic [BL_W-1:0] frame;
  } exp_t;

  exp_t sb[$];
  int   pulse_cyc[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  bit   rst_at_edge = 1'b0;
  int   cyc_start = 0;
  int   pulses = 0;
  bit   abort = 1'b0;
  bit   start_pending = 1'b0;
  bit   mark_start = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_frame(input string name, input logic [BL_W-1:0] act, input logic [BL_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: bl got %h expected %h", name, act, exp);
    end
  endtask

  // Bit i of the returned vector is bl[i], i.e. beat i/DATA_W, bit i%DATA_W.
  function automatic logic [BL_W-1:0] bl_vec();
    logic [BL_W-1:0] v;
    for (int i = 0; i < BL_W; i++) v[i] = bl[i];
    return v;
  endfunction

  always @(posedge prog_clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= pReset;
  end

  bit              in_pulse = 1'b0;
  int              pw = 0;
  logic [BL_W-1:0] bl_prev = '0;
  logic [BL_W-1:0] cur_frame = '0;

  always @(negedge prog_clk) begin : monitor
    logic [BL_W-1:0] bv;
    int              n;
    int              idx;
    exp_t            e;
    bv  = bl_vec();
    n   = 0;
    idx = -1;
    for (int i = 0; i < WL_W; i++) begin
      if (wl[i]) begin
        n++;
        idx = i;
      end
    end
    if (rst_at_edge) begin
      in_pulse = 1'b0;
      pw       = 0;
    end else begin
      chk("wl_multi_hot", n > 1, 0);
      chk("wl_while_ready", (n != 0) && din_ready, 0);
      chk("bl_not_zero_when_idle", (!busy || (din_ready && CHK_BEATS == 0)) && (bv != '0), 0);
      if (n != 0 && !in_pulse) begin
        in_pulse = 1'b1;
        pw       = 1;
        pulses++;
        pulse_cyc.push_back(cyc);
        chk("setup_bl_stable", bl_prev == bv, 1);
        if (sb.size() == 0) begin
          chk("unexpected_pulse_row", idx, -1);
        end else begin
          e = sb.pop_front();
          chk("wl_row", idx, e.row);
          chk_frame("bl_at_pulse", bv, e.frame);
          cur_frame = e.frame;
        end
      end else if (n != 0) begin
        pw++;
      end else if (in_pulse) begin
        chk("pulse_width", pw, PULSE_CYC);
        chk_frame("bl_hold", bv, cur_frame);
        in_pulse = 1'b0;
      end
    end
    bl_prev = bv;
  end

  task automatic send_beat(input logic [DATA_W-1:0] b, input bit gaps, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && !abort) begin
      @(negedge prog_clk);
      if (abort) break;
      start = start_pending;
      if (start_pending && mark_start) begin
        cyc_start  = cyc + 1;
        mark_start = 1'b0;
      end
      start_pending = 1'b0;
      din       = b;
      din_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (din_valid && din_ready) begin
        ok = 1'b1;
      end else begin
        n++;
        if (n > 400) begin
          chk("beat_accept_timeout", n, 0);
          abort = 1'b1;
        end
      end
    end
  endtask

  task automatic send_session(input bit gaps, input bit special0, input bit inject, input int bad_row);
    logic [BL_W-1:0]   f;
    logic [DATA_W-1:0] b;
    bit                ok;
    exp_t              e;
    start_pending = 1'b1;
    mark_start    = 1'b1;
    for (int r = 0; r < WL_W && !abort; r++) begin
      f = '0;
      for (int k = 0; k < BEATS && !abort; k++) begin
        if (special0 && r == 0) b = (k == 0) ? DATA_W'(1) : '0;
        else b = DATA_W'($urandom);
        f[k*DATA_W +: DATA_W] = b;
        if (inject && r == 3 && k == 5) start_pending = 1'b1;
        send_beat(b, gaps, ok);
      end
`ifdef BL_WL_FRAME_PARITY_EN
      b    = DATA_W'($urandom);
      b[0] = (^f) ^ (r == bad_row);
      send_beat(b, gaps, ok);
      if (r == bad_row) return;
`endif
      if (!abort) begin
        e.row   = r;
        e.frame = f;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_done(input string name, output int dc);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge prog_clk);
      n++;
    end
    chk(name, done, 1);
    dc = cyc;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int dc;
    int n;

    pReset = 1'b1;
    repeat (3) @(negedge prog_clk);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_bl", bl != '0, 0);
    chk("rst_wl", wl != '0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    din_valid = 1'b1;
    din       = 8'hA5;
    pReset    = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("idle_no_ready", din_ready, 0);
    chk("idle_not_busy", busy, 0);

    // Session 1: marker frame on row 0, random rows after, no gaps.
    pulses = 0;
    pulse_cyc.delete();
    send_session(1'b0, 1'b1, 1'b0, -1);
    wait_done("s1_done_seen", dc);
    chk("s1_first_pulse_cyc", (pulse_cyc.size() > 0) ? pulse_cyc[0] - cyc_start : -1, FIRST_PULSE);
    chk("s1_second_pulse_cyc", (pulse_cyc.size() > 1) ? pulse_cyc[1] - cyc_start : -1, FIRST_PULSE + ROW_CYC);
    chk("s1_done_cyc", dc - cyc_start, ROW_CYC * WL_W);
    chk("s1_pulses", pulses, WL_W);
    chk("s1_sb_empty", sb.size(), 0);
    repeat (5) @(negedge prog_clk);
    chk("s1_done_level", done, 1);
    chk("s1_done_not_busy", busy, 0);
    chk("s1_done_no_ready", din_ready, 0);

    // Session 2: restart from DONE, random valid gaps, stray start while busy.
    pulses = 0;
    pulse_cyc.delete();
    fork
      send_session(1'b1, 1'b0, 1'b1, -1);
      begin
        @(negedge prog_clk);
        @(negedge prog_clk);
        chk("restart_done_drop", done, 0);
        chk("restart_busy", busy, 1);
      end
    join
    wait_done("s2_done_seen", dc);
    chk("s2_pulses", pulses, WL_W);
    chk("s2_sb_empty", sb.size(), 0);

    // Session 3: reset in the middle of row 5's pulse.
    pulses = 0;
    abort  = 1'b0;
    fork
      send_session(1'b0, 1'b0, 1'b0, -1);
      begin
        n = 0;
        while (!wl[5] && n < 2000) begin
          @(negedge prog_clk);
          n++;
        end
        chk("row5_pulse_seen", wl[5], 1);
        pReset = 1'b1;
        abort  = 1'b1;
        @(negedge prog_clk);
        chk("midrst_wl", wl != '0, 0);
        chk("midrst_bl", bl != '0, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", din_ready, 0);
        chk("midrst_done", done, 0);
        pReset = 1'b0;
      end
    join
    abort = 1'b0;
    sb.delete();
    din_valid = 1'b0;
    start     = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("post_rst_idle_busy", busy, 0);

    // Session 4: full reprogram from row 0 after the reset.
    pulses = 0;
    pulse_cyc.delete();
    send_session(1'b0, 1'b0, 1'b0, -1);
    wait_done("s4_done_seen", dc);
    chk("s4_done_cyc", dc - cyc_start, ROW_CYC * WL_W);
    chk("s4_pulses", pulses, WL_W);
    chk("s4_sb_empty", sb.size(), 0);

`ifdef BL_WL_FRAME_PARITY_EN
    // Session 5: good parity on row 0, bad parity on row 1.
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    pulses = 0;
    send_session(1'b0, 1'b0, 1'b0, 1);
    n = 0;
    while (!err && n < 20) begin
      @(negedge prog_clk);
      n++;
    end
    chk("par_err_set", err, 1);
    chk("par_err_not_busy", busy, 0);
    chk("par_err_no_ready", din_ready, 0);
    repeat (5) @(negedge prog_clk);
    chk("par_pulses", pulses, 1);
    chk("par_sb_empty", sb.size(), 0);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("par_start_ignored_err", err, 1);
    chk("par_start_ignored_busy", busy, 0);
    chk("par_start_ignored_ready", din_ready, 0);
    chk("par_no_more_pulses", pulses, 1);
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    chk("par_err_cleared", err, 0);
`else
    chk("err_tied_low", err, 0);
`endif

    din_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
